uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single PC-side async_transmitter (PC_out) between two requesters: a raw
//   sample echo channel (one byte per request) and a spectrum frame channel (sync byte,
//   NUM_BINS bin bytes read from the bin RAM). Round-robin grant at byte/frame
//   boundaries; paces every byte on the transmitter's start/busy handshake. Sits in
//   main_module between the spectrum/bin RAM, the ADC sample path and async_transmitter.
// PARAMETERS
//   NUM_BINS    32     bins per frame, 2..256
//   ADDR_W      5      bin_addr width, clog2(NUM_BINS)
//   SYNC_BYTE   8'hA5  first byte of every frame
// PORTS
//   cclk          in   1      system clock
//   reset         in   1      asynchronous, active-high reset
//   sample_valid  in   1      sample byte offered
//   sample_data   in   8      sample byte
//   sample_ready  out  1      sample accepted when valid&ready at cclk edge
//   frame_req     in   1      level; frame wanted, held until frame_ack
//   frame_ack     out  1      1-cycle pulse: frame granted, bins frozen from here
//   bin_addr      out  ADDR_W bin RAM read address
//   bin_data      in   8      bin RAM data, valid 1 cycle after bin_addr
//   frame_done    out  1      1-cycle pulse after last frame byte leaves transmitter
//   tx_start      out  1      to async_transmitter TxD_start, 1-cycle pulse
//   tx_data       out  8      to TxD_data, registered, stable from tx_start until idle
//   tx_busy       in   1      from TxD_busy
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, bin index 0, last_grant = FRAME (sample wins first tie).
//   States: IDLE, SAMPLE, FR_SYNC, FR_ADDR, FR_BIN, [FR_CK], SEND, GUARD, DRAIN.
//   IDLE: sample_ready=1 only in IDLE with tx_busy=0 and no frame granted this cycle.
//     Both requesting: grant the one not in last_grant. One requesting: grant it.
//   Sample grant: latch sample_data into tx_data, -> SEND; return target IDLE.
//   Frame grant: frame_ack pulse, index=0, tx_data=SYNC_BYTE, -> SEND; return FR_ADDR.
//   FR_ADDR: bin_addr=index, -> FR_BIN. FR_BIN: tx_data=bin_data (1-cycle RAM latency),
//     -> SEND; return FR_ADDR if index<NUM_BINS-1 (index++), else end-of-frame.
//   SEND: tx_start=1 for exactly 1 cycle -> GUARD (ignore tx_busy 1 cycle, it rises the
//     cycle after start) -> DRAIN: wait tx_busy=0, then go to return target.
//   End-of-frame: frame_done pulses the cycle DRAIN exits after last byte; -> IDLE.
//   Frame is non-preemptible; samples offered during a frame wait (valid held by source).
//   tx_start never asserted while tx_busy=1; back-to-back bytes gap = 3 cycles min.
//   frame_req asserted during own frame: served as a new frame after arbitration.
//   Reset mid-frame: abort immediately to IDLE, no frame_done; a byte already in the
//     transmitter completes, IDLE waits tx_busy=0 before next start.
//   Index wrap: never exceeds NUM_BINS-1; bin_addr holds last value when not reading.
// CONFIGURATION
//   UART_TX_CHECKSUM_EN defined: after last bin, state FR_CK sends one byte = XOR of
//     all NUM_BINS bin bytes (sync excluded); frame_done follows that byte.
//     Frame length NUM_BINS+2 bytes.
//   Not defined: no FR_CK, no checksum logic; frame length NUM_BINS+1 bytes.
// TESTING
//   Bench: cclk 25 MHz, real async_transmitter 115200 baud, async_receiver on TxD.
//   1 Reset, then sample_valid with 8'h3C -> one tx_start, receiver gets 8'h3C,
//     sample_ready low until tx_busy falls.
//   2 frame_req, RAM bin[i]=i+1 -> frame_ack once, receiver gets A5,01..20 (32 bins),
//     frame_done once; with CHECKSUM_EN extra byte 8'h20 (XOR of 1..32).
//   3 sample_valid and frame_req same cycle after reset -> sample sent first, then
//     frame; repeat simultaneous -> frame first (round-robin alternation).
//   4 sample_valid raised at bin 10 of frame -> no tx_start until frame_done, then sample.
//   5 reset asserted during bin 5 -> outputs 0 at once, no frame_done; new frame_req
//     -> first tx_start only after tx_busy low, frame restarts with A5.
//   6 Assertion across all runs: never tx_start while tx_busy=1; tx_start width 1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a sample echo channel and a spectrum frame channel.
// Define UART_TX_CHECKSUM_EN to append an XOR-of-bins checksum byte to every frame.
`timescale 1ns/1ps
module uart_tx_scheduler #(
    parameter int         NUM_BINS  = 32,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              cclk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        sample_data,
    output logic              sample_ready,
    input  logic              frame_req,
    output logic              frame_ack,
    output logic [ADDR_W-1:0] bin_addr,
    input  logic [7:0]        bin_data,
    output logic              frame_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

`ifdef UART_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_GUARD, S_DRAIN, S_FR_ADDR, S_FR_BIN, S_FR_CK
    } state_t;
    typedef enum logic [1:0] {RET_IDLE, RET_ADDR, RET_CK, RET_DONE} ret_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_GUARD, S_DRAIN, S_FR_ADDR, S_FR_BIN
    } state_t;
    typedef enum logic [1:0] {RET_IDLE, RET_ADDR, RET_DONE} ret_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);

    state_t            r_state;
    state_t            w_state_next;
    ret_t              r_ret;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_bin_addr;
    logic [7:0]        r_tx_data;
    logic              r_last_frame;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic w_arb_ok;
    logic w_grant_frame;
    logic w_grant_sample;
    logic w_drain_done;

    // Arbitration only while the transmitter is idle; ties go to whoever did not win last.
    assign w_arb_ok       = (r_state == S_IDLE) && !tx_busy;
    assign w_grant_frame  = w_arb_ok && frame_req && (!sample_valid || !r_last_frame);
    assign w_grant_sample = w_arb_ok && sample_valid && !w_grant_frame;
    assign w_drain_done   = (r_state == S_DRAIN) && !tx_busy;

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_grant_frame || w_grant_sample) w_state_next = S_SEND;
            S_SEND:    w_state_next = S_GUARD;
            S_GUARD:   w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    unique case (r_ret)
                        RET_ADDR: w_state_next = S_FR_ADDR;
`ifdef UART_TX_CHECKSUM_EN
                        RET_CK:   w_state_next = S_FR_CK;
`endif
                        default:  w_state_next = S_IDLE;
                    endcase
                end
            end
            S_FR_ADDR: w_state_next = S_FR_BIN;
            S_FR_BIN:  w_state_next = S_SEND;
`ifdef UART_TX_CHECKSUM_EN
            S_FR_CK:   w_state_next = S_SEND;
`endif
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sample_ready = 1'b0;
        frame_ack    = 1'b0;
        tx_start     = 1'b0;
        frame_done   = 1'b0;
        if (!reset) begin
            sample_ready = w_arb_ok && !w_grant_frame;
            frame_ack    = w_grant_frame;
            tx_start     = (r_state == S_SEND);
            frame_done   = w_drain_done && (r_ret == RET_DONE);
        end
    end

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            r_ret        <= RET_IDLE;
            r_index      <= '0;
            r_bin_addr   <= '0;
            r_tx_data    <= 8'h00;
            r_last_frame <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            if (w_grant_sample) begin
                r_tx_data    <= sample_data;
                r_ret        <= RET_IDLE;
                r_last_frame <= 1'b0;
            end
            if (w_grant_frame) begin
                r_tx_data    <= SYNC_BYTE;
                r_index      <= '0;
                r_bin_addr   <= '0;
                r_ret        <= RET_ADDR;
                r_last_frame <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                r_csum       <= 8'h00;
`endif
            end
            if (r_state == S_FR_ADDR) begin
                r_bin_addr <= r_index;
            end
            if (r_state == S_FR_BIN) begin
                r_tx_data <= bin_data;
`ifdef UART_TX_CHECKSUM_EN
                r_csum    <= r_csum ^ bin_data;
`endif
                if (r_index != LAST_IDX) begin
                    // Address moves on early so RAM data is ready by the next FR_BIN.
                    r_index    <= r_index + 1'b1;
                    r_bin_addr <= r_index + 1'b1;
                    r_ret      <= RET_ADDR;
                end else begin
`ifdef UART_TX_CHECKSUM_EN
                    r_ret      <= RET_CK;
`else
                    r_ret      <= RET_DONE;
`endif
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            if (r_state == S_FR_CK) begin
                r_tx_data <= r_csum;
                r_ret     <= RET_DONE;
            end
`endif
        end
    end

    assign bin_addr = r_bin_addr;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural transmitter and bin RAM model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int NUM_BINS = 32;
    localparam int ADDR_W   = 5;
    localparam int BUSY_CYC = 12;
`ifdef UART_TX_CHECKSUM_EN
    localparam int FLEN = NUM_BINS + 2;
`else
    localparam int FLEN = NUM_BINS + 1;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic              cclk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [7:0]        sample_data;
    logic              sample_ready;
    logic              frame_req;
    logic              frame_ack;
    logic [ADDR_W-1:0] bin_addr;
    logic [7:0]        bin_data = 8'h00;
    logic              frame_done;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_ack    = 0;
    int n_done   = 0;
    int tx_cnt   = 0;
    logic prev_start = 1'b0;
    logic [7:0] ram [0:NUM_BINS-1];
    logic [7:0] tx_q[$];

    uart_tx_scheduler #(.NUM_BINS(NUM_BINS), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .cclk(cclk), .reset(reset),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .frame_req(frame_req), .frame_ack(frame_ack),
        .bin_addr(bin_addr), .bin_data(bin_data), .frame_done(frame_done),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #20 cclk = ~cclk;

    initial begin
        for (int i = 0; i < NUM_BINS; i++) ram[i] = 8'(i + 1);
    end

    always @(posedge cclk) bin_data <= ram[bin_addr];

    // Transmitter: busy rises the cycle after start and stays high BUSY_CYC cycles.
    always @(posedge cclk) begin
        if (tx_start) begin
            tx_cnt <= BUSY_CYC;
            tx_q.push_back(tx_data);
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end
    end
    assign tx_busy = (tx_cnt != 0);

    always @(posedge cclk) begin
        if (tx_start)   n_start <= n_start + 1;
        if (frame_ack)  n_ack   <= n_ack + 1;
        if (frame_done) n_done  <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge cclk) begin
        if (tx_start) begin
            chk("start_while_busy", {31'b0, tx_busy}, 32'd0);
            chk("start_width", {31'b0, prev_start}, 32'd0);
        end
        prev_start <= tx_start;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge cclk);
    endtask

    task automatic send_sample(input logic [7:0] d, input int bound);
        int  k  = 0;
        logic ok = 1'b0;
        sample_data  = d;
        sample_valid = 1'b1;
        while (!ok && k < bound) begin
            #1;
            if (sample_ready) ok = 1'b1;
            @(negedge cclk);
            k++;
        end
        sample_valid = 1'b0;
        chk("sample_accept", {31'b0, ok}, 32'd1);
        $display("sample %02h accepted=%0d after %0d cycles", d, ok, k);
    endtask

    task automatic request_frame(input int bound);
        int  k  = 0;
        logic ok = 1'b0;
        frame_req = 1'b1;
        while (!ok && k < bound) begin
            #1;
            if (frame_ack) ok = 1'b1;
            @(negedge cclk);
            k++;
        end
        frame_req = 1'b0;
        chk("frame_grant", {31'b0, ok}, 32'd1);
        $display("frame granted=%0d after %0d cycles", ok, k);
    endtask

    task automatic wait_bytes(input int n, input int bound, input string tag);
        int k = 0;
        while ((tx_q.size() < n || tx_busy) && k < bound) begin
            @(negedge cclk);
            k++;
        end
        tick(4);
        chk({tag, "_count"}, 32'(tx_q.size()), 32'(n));
    endtask

    function automatic byte_q_t frame_bytes();
        byte_q_t q;
        q.push_back(8'hA5);
        for (int i = 1; i <= NUM_BINS; i++) q.push_back(8'(i));
`ifdef UART_TX_CHECKSUM_EN
        q.push_back(8'h20);
`endif
        return q;
    endfunction

    task automatic check_bytes(input string tag, input byte_q_t exp);
        logic [31:0] got;
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp[i]});
        end
        $display("%s: %0d bytes sent, %0d expected", tag, tx_q.size(), exp.size());
        tx_q.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        int a0, d0, s0;
        byte_q_t e;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 8'h00;
        frame_req    = 1'b0;
        tick(3);
        #1;
        chk("rst_sample_ready", {31'b0, sample_ready}, 32'd0);
        chk("rst_frame_ack",    {31'b0, frame_ack},    32'd0);
        chk("rst_tx_start",     {31'b0, tx_start},     32'd0);
        chk("rst_frame_done",   {31'b0, frame_done},   32'd0);
        chk("rst_tx_data",      {24'h0, tx_data},      32'h0);
        chk("rst_bin_addr",     {27'h0, bin_addr},     32'h0);
        @(negedge cclk);
        reset = 1'b0;

        // 1: single sample echo
        send_sample(8'h3C, 20);
        tick(3);
        chk("t1_ready_while_busy", {31'b0, sample_ready}, 32'd0);
        wait_bytes(1, 200, "t1");
        e = {8'h3C};
        check_bytes("t1", e);
        chk("t1_starts", 32'(n_start), 32'd1);

        // 2: full frame
        a0 = n_ack; d0 = n_done;
        request_frame(50);
        wait_bytes(FLEN, 3000, "t2");
        check_bytes("t2", frame_bytes());
        chk("t2_acks",  32'(n_ack),  32'(a0 + 1));
        chk("t2_dones", 32'(n_done), 32'(d0 + 1));
        chk("t2_bin_addr_hold", {27'h0, bin_addr}, 32'(NUM_BINS - 1));

        // 3: simultaneous requests alternate: sample, frame, sample
        pulse_reset();
        tx_q.delete();
        fork
            begin send_sample(8'h11, 20); send_sample(8'h22, 3000); end
            request_frame(200);
        join
        wait_bytes(FLEN + 2, 3000, "t3");
        e = frame_bytes();
        e.push_front(8'h11);
        e.push_back(8'h22);
        check_bytes("t3", e);

        // 4: sample offered mid-frame waits until frame_done
        d0 = n_done; s0 = n_start;
        request_frame(50);
        begin
            int k = 0;
            while (tx_q.size() < 11 && k < 1000) begin @(negedge cclk); k++; end
        end
        send_sample(8'h77, 3000);
        chk("t4_done_before_sample", 32'(n_done), 32'(d0 + 1));
        chk("t4_starts_before_sample", 32'(n_start - s0), 32'(FLEN));
        wait_bytes(FLEN + 1, 500, "t4");
        e = frame_bytes();
        e.push_back(8'h77);
        check_bytes("t4", e);

        // 5: reset during bin 5 aborts frame without frame_done
        d0 = n_done;
        request_frame(50);
        begin
            int k = 0;
            while (tx_q.size() < 6 && k < 1000) begin @(negedge cclk); k++; end
        end
        #5 reset = 1'b1;
        #1;
        chk("t5_tx_start",     {31'b0, tx_start},     32'd0);
        chk("t5_frame_ack",    {31'b0, frame_ack},    32'd0);
        chk("t5_frame_done",   {31'b0, frame_done},   32'd0);
        chk("t5_sample_ready", {31'b0, sample_ready}, 32'd0);
        chk("t5_tx_data",      {24'h0, tx_data},      32'h0);
        chk("t5_bin_addr",     {27'h0, bin_addr},     32'h0);
        tick(2);
        reset = 1'b0;
        tx_q.delete();
        chk("t5_no_done_on_abort", 32'(n_done), 32'(d0));
        request_frame(50);
        wait_bytes(FLEN, 3000, "t5");
        check_bytes("t5", frame_bytes());
        chk("t5_dones", 32'(n_done), 32'(d0 + 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
